// File: rtl/mem_loader_pkg.sv
// Shared types and encodings for the boot-time program loader.
// Imported by the loader and anything that decodes its state.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/mem_loader.sv
// Boot loader: byte stream -> little-endian words -> memory writes.
// Holds the processor in reset until the whole image is written.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int p_memsize = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [7:0]  in_data,
  output logic        memreq_val,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  output logic        proc_rst,
  output logic        done,
  output logic        err
);

  localparam int IW = $clog2(p_memsize) + 1;
  localparam int AW = IW + 2;
  localparam logic [8:0] MAX_N = 9'(p_memsize);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   n;
  logic [IW-1:0]   idx_inc;
  logic [1:0]      cnt;
  logic [31:0]     word;
  logic            rdy_q;
  logic            wr_q;
  logic            done_q;
  logic            err_q;
  logic            take;

  assign take    = in_val & rdy_q;
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HDR;
      idx    <= '0;
      n      <= '0;
      cnt    <= '0;
      word   <= '0;
      rdy_q  <= 1'b1;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        HDR: begin
          if (take) begin
            if (in_data == 8'd0) begin
              state  <= DONE;
              rdy_q  <= 1'b0;
              done_q <= 1'b1;
            end else if ({1'b0, in_data} > MAX_N) begin
              state <= ERR;
              rdy_q <= 1'b0;
              err_q <= 1'b1;
            end else begin
              state <= DATA;
              n     <= IW'(in_data);
              idx   <= '0;
              cnt   <= '0;
            end
          end
        end
        DATA: begin
          if (take) begin
            word[{cnt, 3'b000} +: 8] <= in_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= WRITE;
              rdy_q <= 1'b0;
              wr_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_q <= 1'b0;
          idx  <= idx_inc;
          if (idx_inc == n) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= DATA;
            rdy_q <= 1'b1;
          end
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= HDR;
      endcase
    end
  end

  // rst overrides the handshake and processor reset immediately
  assign in_rdy       = rdy_q & ~rst;
  assign memreq_val   = wr_q & ~rst;
  assign memreq_type  = MEMREQ_WRITE;
  assign memreq_addr  = {{(32-AW){1'b0}}, idx, 2'b00};
  assign memreq_wdata = word;
  assign proc_rst     = rst | ~done_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader with a queue-based image model.
// Checks write order, data, timing, sticky flags and reset behaviour.
module tb_mem_loader;
  localparam int P = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in_data;
  logic        memreq_val;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        proc_rst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  mem_loader #(.p_memsize(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_data      (in_data),
    .memreq_val   (memreq_val),
    .memreq_type  (memreq_type),
    .memreq_addr  (memreq_addr),
    .memreq_wdata (memreq_wdata),
    .proc_rst     (proc_rst),
    .done         (done),
    .err          (err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dbl = 0;
  int rdy_wr = 0;
  logic prev_val = 1'b0;

  logic [7:0]  acc_q[$];
  int          acc_cyc[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  logic [31:0] mem [P];
  logic [7:0]  tx[$];

  // Passive monitor: accepted bytes, write pulses, memory image
  always @(posedge clk) begin
    if (in_val && in_rdy) begin
      acc_q.push_back(in_data);
      acc_cyc.push_back(cyc);
    end
    if (memreq_val) begin
      wa_q.push_back(memreq_addr);
      wd_q.push_back(memreq_wdata);
      wc_q.push_back(cyc);
      mem[memreq_addr[7:2]] <= memreq_wdata;
      if (prev_val) dbl <= dbl + 1;
      if (in_rdy) rdy_wr <= rdy_wr + 1;
    end
    prev_val <= memreq_val;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_val = 1'b0;
    in_data = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_proc_rst", proc_rst, 1);
    rst = 1'b0;
    acc_q.delete();
    acc_cyc.delete();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dbl = 0;
    rdy_wr = 0;
    #1;
  endtask

  task automatic send(input int gapmax);
    for (int i = 0; i < tx.size(); i++) begin
      int g;
      int t;
      bit ok;
      g = $urandom_range(0, gapmax);
      in_val = 1'b0;
      for (int k = 0; k < g; k++) begin
        @(posedge clk);
        #1;
      end
      in_val = 1'b1;
      in_data = tx[i];
      t = 0;
      do begin
        ok = in_rdy;
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 200);
      if (!ok) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_val = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!done && !err && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("end_reached", done | err, 1);
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {tx[4*i+4], tx[4*i+3], tx[4*i+2], tx[4*i+1]};
  endfunction

  task automatic check_image(input string tag);
    int n;
    int nw;
    int nacc;
    bit bad_hdr;
    n = tx[0];
    bad_hdr = (n > P);
    nw = bad_hdr ? 0 : n;
    nacc = bad_hdr ? 1 : 1 + 4 * n;
    chk({tag, "_nacc"}, acc_q.size(), nacc);
    for (int i = 0; i < nacc && i < acc_q.size(); i++)
      chk({tag, "_byte"}, acc_q[i], tx[i]);
    chk({tag, "_nwr"}, wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, wa_q[i], 4 * i);
      chk({tag, "_wdata"}, wd_q[i], model_word(i));
    end
    chk({tag, "_done"}, done, !bad_hdr);
    chk({tag, "_err"}, err, bad_hdr);
    chk({tag, "_proc_rst"}, proc_rst, bad_hdr);
    chk({tag, "_in_rdy"}, in_rdy, 0);
    chk({tag, "_dbl_pulse"}, dbl, 0);
    chk({tag, "_rdy_in_wr"}, rdy_wr, 0);
  endtask

  task automatic rand_image(input int n);
    tx.delete();
    tx.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst = 1'b1;
    in_val = 1'b0;
    in_data = 8'h00;

    do_reset();
    chk("reset_in_rdy", in_rdy, 1);
    chk("reset_memreq_val", memreq_val, 0);
    chk("reset_memreq_type", memreq_type, 1);
    chk("reset_memreq_addr", memreq_addr, 0);
    chk("reset_memreq_wdata", memreq_wdata, 0);
    chk("reset_proc_rst", proc_rst, 1);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);

    // Empty image: done on the very next cycle, input stays blocked
    tx = '{8'd0};
    send(0);
    chk("n0_done_next", done, 1);
    chk("n0_proc_rst", proc_rst, 0);
    in_val = 1'b1;
    in_data = 8'hA5;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("n0_in_rdy_low", in_rdy, 0);
    end
    in_val = 1'b0;
    check_image("n0");

    // One word back-to-back with cycle-exact timing
    do_reset();
    tx = '{8'd1, 8'h13, 8'h05, 8'h10, 8'h00};
    send(0);
    chk("n1_write_now", memreq_val, 1);
    chk("n1_type", memreq_type, 1);
    chk("n1_in_rdy_wr", in_rdy, 0);
    @(posedge clk);
    #1;
    chk("n1_done", done, 1);
    chk("n1_proc_rst", proc_rst, 0);
    chk("n1_write_cycle", wc_q.size() > 0 ? wc_q[0] - acc_cyc[0] : -1, 5);
    chk("n1_wdata_lit", wd_q.size() > 0 ? wd_q[0] : 0, 32'h00100513);
    check_image("n1");

    // Two words with random valid gaps
    do_reset();
    tx = '{8'd2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send(3);
    wait_end();
    check_image("n2");

    // Oversized header: error, nothing written, data ignored
    do_reset();
    tx = '{8'd65};
    send(0);
    in_val = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    check_image("err65");

    // Reset mid-load, then a fresh image must not see stale bytes
    do_reset();
    rand_image(3);
    begin
      logic [7:0] full[$];
      full = tx;
      tx = full[0:6];
    end
    send(0);
    chk("mid_one_write", wa_q.size(), 1);
    do_reset();
    rand_image(1);
    send(1);
    wait_end();
    check_image("after_rst");

    // Full memory image, then readback of the captured memory
    do_reset();
    rand_image(P);
    send(0);
    wait_end();
    check_image("full");
    chk("full_last_addr", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 0, 32'hFC);
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++) chk("full_readback", mem[i], model_word(i));

    // Random sizes and gaps
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_image($urandom_range(1, P));
      send(2);
      wait_end();
      check_image("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
